rx_gen: RTL and testbench
=========================

RX_GEN -- requirements
Module: rx_gen

Interface
REQ-001 Parameter DATA_BITS, 8, frame data width; legal 5..8.
REQ-002 Parameter PARITY, 0, 0 none / 1 odd / 2 even.
REQ-003 Parameter STOP_BITS, 1, stop bits checked; legal 1 or 2.
REQ-004 Parameter OVS, 16, ena ticks per bit; legal even 8..32.
REQ-005 Parameter AW, 4, FIFO address width; depth = 2**AW words.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 ena  in  1  oversample tick, one clk wide, OVS per bit time.
REQ-009 rxd  in  1  asynchronous serial input, idle high.
REQ-010 rx_fifo_ren  in  1  FIFO read request.
REQ-011 err_clr  in  1  clears rx_overflow, parity_err, frame_err.
REQ-012 rx_fifo_rdata  out  DATA_BITS  FIFO read data.
REQ-013 rx_fifo_empty  out  1  FIFO empty.
REQ-014 rx_fifo_full  out  1  FIFO full.
REQ-015 rx_fifo_usedw  out  AW+1  words held, 0..2**AW.
REQ-016 rx_overflow  out  1  sticky: frame dropped because FIFO full.
REQ-017 parity_err  out  1  sticky: parity mismatch seen.
REQ-018 frame_err  out  1  sticky: stop bit sampled low.

Function
REQ-019 rxd passes a 2-flop synchroniser reset to 1 before any use; all sampling uses the synchronised value.
REQ-020 FSM states IDLE, START, DATA, PARITY, STOP; tick counter and bit counter advance only on ena.
REQ-021 IDLE -> START on synchronised falling edge (previous 1, current 0); tick counter cleared.
REQ-022 START: at tick OVS/2-1 sample; 0 -> DATA with counter cleared; 1 -> IDLE (glitch, no flags).
REQ-023 DATA: sample every OVS ticks, LSB first, DATA_BITS samples; then PARITY if PARITY!=0 else STOP.
REQ-024 PARITY: one sample after OVS ticks; odd requires odd count of ones over data+parity bit, even requires even; mismatch marks frame bad-parity.
REQ-025 STOP: STOP_BITS samples at OVS spacing; any 0 marks frame bad-stop; after last sample -> IDLE in same ena cycle, ready for next edge.
REQ-026 Frame complete: data written to FIFO one clk after last stop sample if not full, regardless of parity/stop errors.
REQ-027 Bad parity sets parity_err; bad stop sets frame_err; both on completion cycle.
REQ-028 Completion while full (after same-cycle read considered): data dropped, rx_overflow set, FIFO unchanged.
REQ-029 Completion while full with rx_fifo_ren asserted and not empty: write accepted, usedw unchanged, no overflow.
REQ-030 Sticky flags: err_clr clears; same-cycle set and err_clr -> flag set (set wins).
REQ-031 FIFO: synchronous, 2**AW words, circular pointers wrap modulo depth; rdata registered, valid one clk after accepted ren.
REQ-032 ren while empty ignored: pointers, usedw, rdata unchanged, no underflow.
REQ-033 empty = (usedw==0), full = (usedw==2**AW), both combinational from count.
REQ-034 Simultaneous read and write when not empty and not full: both occur, usedw unchanged.
REQ-035 rdata of a word written on clk N readable by ren on clk N+1 at earliest.

Reset
REQ-036 rst on any clk edge returns FSM to IDLE, counters to 0, synchroniser to 1, FIFO pointers to 0, mid-frame data discarded.
REQ-037 Reset outputs: rx_fifo_rdata 0, rx_fifo_empty 1, rx_fifo_full 0, rx_fifo_usedw 0, rx_overflow 0, parity_err 0, frame_err 0.
REQ-038 After rst deassert, a frame whose start edge occurs at least 3 clk later is received correctly.

Verification
REQ-039 Defaults, send 0xA5 8N1 -> usedw 1 after stop; ren -> rdata 0xA5 next clk, empty 1, all flags 0.
REQ-040 PARITY=2, send 0x03 with parity bit 1 -> word 0x03 stored, parity_err 1; err_clr -> 0.
REQ-041 AW=2, send 5 frames no reads -> usedw 4, full 1, rx_overflow 1, reads return frames 1..4 in order.
REQ-042 Full FIFO, assert ren on completion cycle of 5th frame -> usedw stays 4, rx_overflow 0, 5th word read last.
REQ-043 Stop bit driven 0 -> word stored, frame_err 1; 0-pulse shorter than OVS/2 ticks -> no store, no flags.
REQ-044 rst pulsed mid DATA state -> all outputs at reset values; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/rx_gen.sv
// Oversampled UART receiver: 2-flop synchroniser, start/data/parity/stop FSM,
// and a synchronous receive FIFO with sticky overflow/parity/framing flags.
module rx_gen #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OVS       = 16,
  parameter int AW        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 rxd,
  input  logic                 rx_fifo_ren,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rx_fifo_rdata,
  output logic                 rx_fifo_empty,
  output logic                 rx_fifo_full,
  output logic [AW:0]          rx_fifo_usedw,
  output logic                 rx_overflow,
  output logic                 parity_err,
  output logic                 frame_err
);
  localparam int TW    = $clog2(OVS);
  localparam int DEPTH = 2 ** AW;
  localparam logic [TW-1:0] HALF     = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULLT    = TW'(OVS - 1);
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic                 sync1_q, sync2_q, prev_q;
  state_t               st_q;
  logic [TW-1:0]        tick_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 bad_par_q, bad_stop_q, done_q;

  logic hit, par_ones, par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // START samples mid-bit; every later sample is one full bit period on.
  assign hit      = (st_q == S_START) ? (tick_q == HALF) : (tick_q == FULLT);
  assign par_ones = ^{sh_q, sync2_q};
  assign par_bad  = (PARITY == 1) ? ~par_ones : par_ones;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      bad_par_q  <= 1'b0;
      bad_stop_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        S_IDLE: begin
          if (prev_q && !sync2_q) begin
            st_q       <= S_START;
            tick_q     <= '0;
            bit_q      <= '0;
            bad_par_q  <= 1'b0;
            bad_stop_q <= 1'b0;
          end
        end
        default: begin
          if (ena) begin
            if (!hit) begin
              tick_q <= tick_q + 1'b1;
            end else begin
              tick_q <= '0;
              case (st_q)
                S_START: st_q <= sync2_q ? S_IDLE : S_DATA;
                S_DATA: begin
                  sh_q <= {sync2_q, sh_q[DATA_BITS-1:1]};
                  if (bit_q == 4'(DATA_BITS - 1)) begin
                    bit_q <= '0;
                    st_q  <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                    bit_q <= bit_q + 4'd1;
                  end
                end
                S_PARITY: begin
                  bad_par_q <= par_bad;
                  st_q      <= S_STOP;
                end
                S_STOP: begin
                  bad_stop_q <= bad_stop_q | ~sync2_q;
                  if (bit_q == 4'(STOP_BITS - 1)) begin
                    bit_q  <= '0;
                    st_q   <= S_IDLE;
                    done_q <= 1'b1;
                  end else begin
                    bit_q <= bit_q + 4'd1;
                  end
                end
                default: st_q <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [AW:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0] rdata_q;
  logic                 ovf_q, perr_q, ferr_q;
  logic                 rd, wr, ovf_set;

  assign rx_fifo_empty = (cnt_q == '0);
  assign rx_fifo_full  = (cnt_q == FULL_CNT);
  // A same-cycle read frees the slot a completing frame needs.
  assign rd      = rx_fifo_ren && !rx_fifo_empty;
  assign wr      = done_q && (!rx_fifo_full || rd);
  assign ovf_set = done_q && rx_fifo_full && !rd;

  always_comb begin
    cnt_d = cnt_q;
    if (wr && !rd)      cnt_d = cnt_q + 1'b1;
    else if (rd && !wr) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) begin
        rdata_q <= mem_q[rptr_q];
        rptr_q  <= rptr_q + 1'b1;
      end
      cnt_q  <= cnt_d;
      ovf_q  <= (ovf_q  & ~err_clr) | ovf_set;
      perr_q <= (perr_q & ~err_clr) | (done_q & bad_par_q);
      ferr_q <= (ferr_q & ~err_clr) | (done_q & bad_stop_q);
    end
  end

  assign rx_fifo_rdata = rdata_q;
  assign rx_fifo_usedw = cnt_q;
  assign rx_overflow   = ovf_q;
  assign parity_err    = perr_q;
  assign frame_err     = ferr_q;
endmodule

// File: tb/tb_rx_gen.sv
// Directed bench for rx_gen: default 8N1, even-parity, and AW=2 instances
// driven with hand-built frames; ena ticks once every 4 clocks.
module tb_rx_gen;
  localparam int BT = 64;  // clocks per bit: 16 ticks x 4 clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [1:0] div = 2'd0;
  logic [2:0] rxd = 3'b111;
  logic [2:0] ren = 3'b000;
  logic [2:0] eclr = 3'b000;

  logic [7:0] rdata0, rdata1, rdata2;
  logic [4:0] usedw0, usedw1;
  logic [2:0] usedw2;
  logic [2:0] empty, full, ovf, perr, ferr;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div <= div + 2'd1;
    ena <= (div == 2'd3);
  end

  rx_gen dut0 (
    .clk(clk), .rst(rst), .ena(ena), .rxd(rxd[0]), .rx_fifo_ren(ren[0]), .err_clr(eclr[0]),
    .rx_fifo_rdata(rdata0), .rx_fifo_empty(empty[0]), .rx_fifo_full(full[0]),
    .rx_fifo_usedw(usedw0), .rx_overflow(ovf[0]), .parity_err(perr[0]), .frame_err(ferr[0]));

  rx_gen #(.PARITY(2)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .rxd(rxd[1]), .rx_fifo_ren(ren[1]), .err_clr(eclr[1]),
    .rx_fifo_rdata(rdata1), .rx_fifo_empty(empty[1]), .rx_fifo_full(full[1]),
    .rx_fifo_usedw(usedw1), .rx_overflow(ovf[1]), .parity_err(perr[1]), .frame_err(ferr[1]));

  rx_gen #(.AW(2)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .rxd(rxd[2]), .rx_fifo_ren(ren[2]), .err_clr(eclr[2]),
    .rx_fifo_rdata(rdata2), .rx_fifo_empty(empty[2]), .rx_fifo_full(full[2]),
    .rx_fifo_usedw(usedw2), .rx_overflow(ovf[2]), .parity_err(perr[2]), .frame_err(ferr[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] rdat(input int u);
    case (u)
      0:       rdat = rdata0;
      1:       rdat = rdata1;
      default: rdat = rdata2;
    endcase
  endfunction

  function automatic logic [4:0] used(input int u);
    case (u)
      0:       used = usedw0;
      1:       used = usedw1;
      default: used = {2'b00, usedw2};
    endcase
  endfunction

  function automatic logic [15:0] fr8(input logic [7:0] d, input logic sb);
    fr8 = {6'b0, sb, d, 1'b0};
  endfunction

  function automatic logic [15:0] frp(input logic [7:0] d, input logic p);
    frp = {5'b0, 1'b1, p, d, 1'b0};
  endfunction

  // Bits go out LSB first, each held one bit time, then the line idles high.
  task automatic send(input int u, input logic [15:0] bits, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rxd[u] = bits[i];
      repeat (BT) @(negedge clk);
    end
    rxd[u] = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // Run alongside send(): pulses ren (kind 0) or err_clr (kind 1) on the clock
  // right after the last stop sample. Start edge is seen 3 posedges after the
  // drive; the last stop sample of an 8N1 frame is the 152nd tick after that.
  task automatic pulse_done(input int u, input int nena, input int kind);
    int n;
    @(negedge clk);
    repeat (3) @(posedge clk);
    n = 0;
    while (n < nena) begin
      @(posedge clk);
      if (ena) n++;
    end
    @(negedge clk);
    if (kind == 0) ren[u] = 1'b1; else eclr[u] = 1'b1;
    @(negedge clk);
    ren[u] = 1'b0;
    eclr[u] = 1'b0;
  endtask

  task automatic rd(input int u, input logic [7:0] exp, input string tag);
    @(negedge clk) ren[u] = 1'b1;
    @(negedge clk) ren[u] = 1'b0;
    chk(tag, 32'(rdat(u)), 32'(exp));
  endtask

  task automatic clr(input int u);
    @(negedge clk) eclr[u] = 1'b1;
    @(negedge clk) eclr[u] = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_rdata", 32'(rdata0), 32'h0);
    chk("rst_empty", 32'(empty[0]), 32'h1);
    chk("rst_full", 32'(full[0]), 32'h0);
    chk("rst_usedw", 32'(usedw0), 32'h0);
    chk("rst_ovf", 32'(ovf[0]), 32'h0);
    chk("rst_perr", 32'(perr[0]), 32'h0);
    chk("rst_ferr", 32'(ferr[0]), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    send(0, fr8(8'hA5, 1'b1), 10);
    chk("a5_usedw", 32'(usedw0), 32'h1);
    chk("a5_empty", 32'(empty[0]), 32'h0);
    rd(0, 8'hA5, "a5_rdata");
    chk("a5_empty_after", 32'(empty[0]), 32'h1);
    chk("a5_flags", 32'({ovf[0], perr[0], ferr[0]}), 32'h0);
    rd(0, 8'hA5, "empty_read_keeps_rdata");
    chk("empty_read_usedw", 32'(used(0)), 32'h0);

    // Even parity: 0x03 with parity 1 is bad, 0x07 with parity 1 is good
    send(1, frp(8'h03, 1'b1), 11);
    chk("par_usedw", 32'(used(1)), 32'h1);
    chk("par_err", 32'(perr[1]), 32'h1);
    chk("par_ferr", 32'(ferr[1]), 32'h0);
    rd(1, 8'h03, "par_rdata");
    clr(1);
    chk("par_clr", 32'(perr[1]), 32'h0);
    send(1, frp(8'h07, 1'b1), 11);
    chk("par_good_err", 32'(perr[1]), 32'h0);
    rd(1, 8'h07, "par_good_rdata");

    // Stop bit low still stores the word
    send(0, fr8(8'h3C, 1'b0), 10);
    chk("stop0_usedw", 32'(usedw0), 32'h1);
    chk("stop0_ferr", 32'(ferr[0]), 32'h1);
    chk("stop0_perr", 32'(perr[0]), 32'h0);
    rd(0, 8'h3C, "stop0_rdata");
    clr(0);
    chk("ferr_clr", 32'(ferr[0]), 32'h0);
    fork
      send(0, fr8(8'hC3, 1'b0), 10);
      pulse_done(0, 152, 1);
    join
    chk("set_beats_clr", 32'(ferr[0]), 32'h1);
    rd(0, 8'hC3, "set_beats_clr_rdata");
    clr(0);

    // Short low glitch (4 ticks) is ignored
    @(negedge clk) rxd[0] = 1'b0;
    repeat (16) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (800) @(negedge clk);
    chk("glitch_usedw", 32'(usedw0), 32'h0);
    chk("glitch_flags", 32'({ovf[0], perr[0], ferr[0]}), 32'h0);
    send(0, fr8(8'h81, 1'b1), 10);
    rd(0, 8'h81, "after_glitch_rdata");

    // AW=2: five frames, no reads
    send(2, fr8(8'h11, 1'b1), 10);
    send(2, fr8(8'h22, 1'b1), 10);
    send(2, fr8(8'h33, 1'b1), 10);
    send(2, fr8(8'h44, 1'b1), 10);
    chk("fill_ovf_before", 32'(ovf[2]), 32'h0);
    send(2, fr8(8'h55, 1'b1), 10);
    chk("ovf_usedw", 32'(used(2)), 32'h4);
    chk("ovf_full", 32'(full[2]), 32'h1);
    chk("ovf_flag", 32'(ovf[2]), 32'h1);
    rd(2, 8'h11, "ovf_rd1");
    rd(2, 8'h22, "ovf_rd2");
    rd(2, 8'h33, "ovf_rd3");
    rd(2, 8'h44, "ovf_rd4");
    chk("ovf_drained", 32'(empty[2]), 32'h1);
    clr(2);
    chk("ovf_clr", 32'(ovf[2]), 32'h0);

    // Full FIFO with a read on the completion clock
    send(2, fr8(8'h66, 1'b1), 10);
    send(2, fr8(8'h77, 1'b1), 10);
    send(2, fr8(8'h88, 1'b1), 10);
    send(2, fr8(8'h99, 1'b1), 10);
    fork
      send(2, fr8(8'hAA, 1'b1), 10);
      pulse_done(2, 152, 0);
    join
    chk("rw_full_rdata", 32'(rdata2), 32'h66);
    chk("rw_full_usedw", 32'(used(2)), 32'h4);
    chk("rw_full_ovf", 32'(ovf[2]), 32'h0);
    rd(2, 8'h77, "rw_rd1");
    rd(2, 8'h88, "rw_rd2");
    rd(2, 8'h99, "rw_rd3");
    rd(2, 8'hAA, "rw_rd4");

    // Reset in the middle of DATA
    send(0, fr8(8'h11, 1'b1), 10);
    send(0, fr8(8'h22, 1'b0), 10);
    rd(0, 8'h11, "pre_rst_rdata");
    @(negedge clk) rxd[0] = 1'b0;
    repeat (BT) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (BT) @(negedge clk);
    rxd[0] = 1'b0;
    repeat (BT) @(negedge clk);
    rst = 1'b1;
    rxd[0] = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mid_rst_rdata", 32'(rdata0), 32'h0);
    chk("mid_rst_empty", 32'(empty[0]), 32'h1);
    chk("mid_rst_full", 32'(full[0]), 32'h0);
    chk("mid_rst_usedw", 32'(usedw0), 32'h0);
    chk("mid_rst_flags", 32'({ovf[0], perr[0], ferr[0]}), 32'h0);
    repeat (3) @(negedge clk);
    send(0, fr8(8'h5A, 1'b1), 10);
    chk("post_rst_usedw", 32'(usedw0), 32'h1);
    rd(0, 8'h5A, "post_rst_rdata");
    chk("post_rst_ferr", 32'(ferr[0]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
